// File: rtl/fp16_add_sequencer.sv
// rtl/fp16_add_sequencer.sv - multi-cycle half-precision add/sub sequencer
// Truncating adder; zero-exponent operands flush to zero, saturation to infinity on exponent overflow.
module fp16_add_sequencer #(
  parameter int EXP_W     = 5,
  parameter int MAN_W     = 10,
  parameter int ALIGN_CAP = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     done,
  output logic                     overflow
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int DW = $clog2(ALIGN_CAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic             r_sign, r_sub, r_c, r_ovf;
  logic [EXP_W-1:0] r_exp;
  logic [M-1:0]     r_mant_a, r_mant_b, r_sum;
  logic [DW-1:0]    r_d;
  logic [W-1:0]     r_result;

  logic             w_sign_a, w_sign_b, w_a_ge;
  logic [EXP_W-1:0] w_exp_a, w_exp_b, w_big_exp, w_small_exp, w_diff;
  logic [M-1:0]     w_mant_a, w_mant_b;
  logic [DW-1:0]    w_d;

  assign w_sign_a = a[W-1];
  assign w_sign_b = b[W-1];
  assign w_exp_a  = a[W-2 -: EXP_W];
  assign w_exp_b  = b[W-2 -: EXP_W];
  assign w_mant_a = (w_exp_a == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
  assign w_mant_b = (w_exp_b == '0) ? '0 : {1'b1, b[MAN_W-1:0]};

  // Larger magnitude always goes to the A side so subtraction never goes negative.
  assign w_a_ge      = {w_exp_a, w_mant_a} >= {w_exp_b, w_mant_b};
  assign w_big_exp   = w_a_ge ? w_exp_a : w_exp_b;
  assign w_small_exp = w_a_ge ? w_exp_b : w_exp_a;
  assign w_diff      = w_big_exp - w_small_exp;
  assign w_d         = (w_diff > EXP_W'(ALIGN_CAP)) ? DW'(ALIGN_CAP) : DW'(w_diff);

  logic [M:0]   w_carry;
  logic [M-1:0] w_b_op, w_add_sum;

  // Ripple mantissa adder; subtraction is A + ~B + 1.
  always_comb begin
    w_b_op     = r_sub ? ~r_mant_b : r_mant_b;
    w_carry    = '0;
    w_carry[0] = r_sub;
    w_add_sum  = '0;
    for (int i = 0; i < M; i++) begin
      w_add_sum[i]   = r_mant_a[i] ^ w_b_op[i] ^ w_carry[i];
      w_carry[i+1]   = (r_mant_a[i] & w_b_op[i]) | (w_carry[i] & (r_mant_a[i] ^ w_b_op[i]));
    end
  end

  logic [EXP_W-1:0] w_exp_inc, w_exp_dec;
  logic             w_ovf_hit, w_uf_hit, w_sum_zero;

  assign w_exp_inc  = r_exp + 1'b1;
  assign w_exp_dec  = r_exp - 1'b1;
  assign w_ovf_hit  = &w_exp_inc;
  assign w_uf_hit   = (w_exp_dec == '0);
  assign w_sum_zero = (r_sum == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ALIGN;
      S_ALIGN: if (r_d == '0) w_state_next = S_ADD;
      S_ADD:   w_state_next = S_NORM;
      S_NORM: begin
        if (r_c) begin
          if (w_ovf_hit) w_state_next = S_DONE;
        end else if (w_sum_zero) begin
          w_state_next = S_DONE;
        end else if (!r_sum[M-1]) begin
          if (w_uf_hit) w_state_next = S_DONE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign   <= 1'b0;
      r_sub    <= 1'b0;
      r_c      <= 1'b0;
      r_ovf    <= 1'b0;
      r_exp    <= '0;
      r_mant_a <= '0;
      r_mant_b <= '0;
      r_sum    <= '0;
      r_d      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_sign   <= w_a_ge ? w_sign_a : w_sign_b;
          r_sub    <= w_sign_a ^ w_sign_b;
          r_exp    <= w_big_exp;
          r_mant_a <= w_a_ge ? w_mant_a : w_mant_b;
          r_mant_b <= w_a_ge ? w_mant_b : w_mant_a;
          r_d      <= w_d;
        end
        S_ALIGN: if (r_d != '0) begin
          r_mant_b <= r_mant_b >> 1;
          r_d      <= r_d - 1'b1;
        end
        S_ADD: begin
          r_sum <= w_add_sum;
          r_c   <= r_sub ? 1'b0 : w_carry[M];
        end
        S_NORM: begin
          if (r_c) begin
            r_sum <= {1'b1, r_sum[M-1:1]};
            r_exp <= w_exp_inc;
            r_c   <= 1'b0;
            if (w_ovf_hit) begin
              r_result <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              r_ovf    <= 1'b1;
            end
          end else if (w_sum_zero) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
          end else if (!r_sum[M-1]) begin
            r_sum <= r_sum << 1;
            r_exp <= w_exp_dec;
            if (w_uf_hit) begin
              r_result <= {r_sign, {(W-1){1'b0}}};
              r_ovf    <= 1'b0;
            end
          end else begin
            r_result <= {r_sign, r_exp, r_sum[MAN_W-1:0]};
            r_ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign done     = (r_state == S_DONE);
  assign overflow = done & r_ovf;
  assign result   = r_result;
endmodule

// File: tb/tb_fp16_add_sequencer.sv
// tb/tb_fp16_add_sequencer.sv - randomized bench for fp16_add_sequencer
// Integer-arithmetic reference model predicts result, overflow and done latency.
module tb_fp16_add_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, ready, done, overflow;
  logic [15:0] a, b, result;
  logic [15:0] last_result;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  fp16_add_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ready(ready), .result(result), .done(done), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Value-level model: real magnitudes as integers, loop-based normalisation.
  function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] res, output logic ovf, output int lat);
    int ex, ey, mx, my, sx, sy, ea, eb, ma, mb, sa, sb, d, s, e, nc;
    bit flushed;
    ex = int'(x[14:10]); ey = int'(y[14:10]);
    mx = (ex == 0) ? 0 : 1024 + int'(x[9:0]);
    my = (ey == 0) ? 0 : 1024 + int'(y[9:0]);
    sx = int'(x[15]); sy = int'(y[15]);
    if (ex * 2048 + mx >= ey * 2048 + my) begin
      ea = ex; ma = mx; sa = sx; eb = ey; mb = my; sb = sy;
    end else begin
      ea = ey; ma = my; sa = sy; eb = ex; mb = mx; sb = sx;
    end
    d = ea - eb;
    if (d > 12) d = 12;
    mb = mb >> d;
    s = (sa == sb) ? ma + mb : ma - mb;
    e = ea; ovf = 1'b0; nc = 0; res = 16'h0;
    if (s >= 2048) begin
      nc = 1; s = s / 2; e = e + 1;
      if (e == 31) begin
        ovf = 1'b1;
        res = 16'(sa * 32768 + 31 * 1024);
      end else begin
        nc = 2;
        res = 16'(sa * 32768 + e * 1024 + s % 1024);
      end
    end else if (s == 0) begin
      nc = 1;
      res = 16'h0000;
    end else begin
      flushed = 1'b0;
      while (s < 1024) begin
        nc++; s = s * 2; e = e - 1;
        if (e == 0) begin
          flushed = 1'b1;
          break;
        end
      end
      if (flushed) res = 16'(sa * 32768);
      else begin
        nc++;
        res = 16'(sa * 32768 + e * 1024 + s % 1024);
      end
    end
    lat = d + 3 + nc;
  endfunction

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input string tag,
                        output logic [15:0] got_res, output int got_lat);
    logic [15:0] er;
    logic        eo;
    int          el, cyc;
    bit          seen;
    model(x, y, er, eo, el);
    @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_idle_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_hold"}, 32'(result), 32'(last_result));
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_busy"}, 32'(ready), 32'd0);
      if (done) seen = 1'b1;
      else begin
        start = 1'($urandom % 2);
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(el));
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    got_res = result;
    got_lat = cyc;
    last_result = er;
  endtask

  logic [15:0] dir_a [10] = '{16'h3C00, 16'h4000, 16'h3C00, 16'h3C01, 16'h7BFF,
                              16'hFBFF, 16'h3C00, 16'h5C00, 16'h0000, 16'h0400};
  logic [15:0] dir_b [10] = '{16'h3C00, 16'h3800, 16'hBC00, 16'hBC00, 16'h7BFF,
                              16'hFBFF, 16'h0001, 16'h3C00, 16'h8000, 16'h8001};

  initial begin
    logic [15:0] r, x, y;
    int          l, ndone;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; last_result = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(dir_a[i], dir_b[i], $sformatf("dir%0d", i), r, l);
      if (i == 0) begin
        check("one_plus_one_res", 32'(r), 32'h4000);
        check("one_plus_one_lat", 32'(l), 32'd5);
      end
      if (i == 3) begin
        check("cancel_res", 32'(r), 32'h1400);
        check("cancel_lat", 32'(l), 32'd14);
      end
      if (i == 4) check("sat_pos_res", 32'(r), 32'h7C00);
      if (i == 5) check("sat_neg_res", 32'(r), 32'hFC00);
    end

    // Reset in the middle of a long alignment must discard the operation.
    @(negedge clk);
    a = 16'h6000; b = 16'h0400; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 16'h3C00; b = 16'h3C00;
    @(negedge clk);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_late_done", 32'(ndone), 32'd0);
    last_result = '0;

    for (int i = 0; i < 400; i++) begin
      x = 16'($urandom);
      x[14:10] = 5'($urandom_range(0, 30));
      y = 16'($urandom);
      if ($urandom % 4 == 0) begin
        y[15] = ~x[15];
        y[14:10] = (x[14:10] > 5'd1) ? x[14:10] - 5'($urandom_range(0, 1)) : x[14:10];
      end else begin
        y[14:10] = 5'($urandom_range(0, 30));
      end
      run_op(x, y, $sformatf("rnd%0d", i), r, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
